run_controller: RTL and testbench

Synthesizable, parametrised boot sequencer and run-budget controller for the custom 8-bit computer. After system reset it holds every reset domain (CPU, memory, I/O) for a fixed number of cycles, then releases them in staggered order. It then counts run cycles against a budget and stops the machine on budget expiry or on a halt request. It replaces the fixed "reset after N clocks, stop after M clocks" sequencing, works on hardware as well as in simulation, and supports multiple domains and restart.

---
 rtl/run_controller.sv | 122 ++++++++++++
 tb/tb_run_controller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
// Boot sequencer and run-budget controller: staggered per-domain reset release, budgeted run, stop/restart.
// Optional feature macro: RUN_CONTROLLER_HALT_EN enables halt_req; without it runs end only on budget expiry.
module run_controller #(
   parameter int NUM_DOMAINS    = 2,
   parameter int HOLD_CYCLES    = 10,
   parameter int STAGGER_CYCLES = 4,
   parameter int RUN_CYCLES     = 500000,
   parameter int CNT_W          = 21,
   parameter int AUTO_RESTART   = 0
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   halt_req,
   input  logic                   restart,
   output logic [NUM_DOMAINS-1:0] domain_rst_n,
   output logic                   running,
   output logic                   done,
   output logic                   halted,
   output logic [CNT_W-1:0]       cycle_count,
   output logic [1:0]             state
);

   localparam logic [1:0] ST_HOLD    = 2'd0;
   localparam logic [1:0] ST_RELEASE = 2'd1;
   localparam logic [1:0] ST_RUN     = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam int TMR_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] STAGGER_LAST = TMR_W'(STAGGER_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LIMIT    = CNT_W'(RUN_CYCLES);

   logic [TMR_W-1:0]       timer;
   logic [NUM_DOMAINS-1:0] dom_shift;
   logic [CNT_W-1:0]       cnt_inc;
   logic                   halt_hit;
   logic                   budget_hit;

   // Domains release as a thermometer code: shifting in a 1 releases the next domain.
   assign dom_shift = NUM_DOMAINS'({domain_rst_n, 1'b1});

   // Saturating increment keeps an unbounded run from wrapping.
   assign cnt_inc    = (&cycle_count) ? cycle_count : cycle_count + CNT_W'(1);
   assign budget_hit = (RUN_CYCLES != 0) && (cnt_inc == RUN_LIMIT);

`ifdef RUN_CONTROLLER_HALT_EN
   assign halt_hit = halt_req;
`else
   logic unused_halt;
   assign unused_halt = halt_req;
   assign halt_hit    = 1'b0;
`endif

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state        <= ST_HOLD;
         timer        <= '0;
         domain_rst_n <= '0;
         running      <= 1'b0;
         done         <= 1'b0;
         halted       <= 1'b0;
         cycle_count  <= '0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (timer == HOLD_LAST) begin
                  timer        <= '0;
                  domain_rst_n <= dom_shift;
                  if (&dom_shift) begin
                     state       <= ST_RUN;
                     running     <= 1'b1;
                     cycle_count <= '0;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ST_RELEASE: begin
               if (timer == STAGGER_LAST) begin
                  timer        <= '0;
                  domain_rst_n <= dom_shift;
                  if (&dom_shift) begin
                     state       <= ST_RUN;
                     running     <= 1'b1;
                     cycle_count <= '0;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            ST_RUN: begin
               // The stopping edge still counts its own cycle.
               cycle_count <= cnt_inc;
               if (halt_hit || budget_hit) begin
                  state        <= ST_DONE;
                  running      <= 1'b0;
                  done         <= 1'b1;
                  halted       <= halt_hit;
                  domain_rst_n <= '0;
               end
            end
            ST_DONE: begin
               if (restart || (AUTO_RESTART != 0)) begin
                  state       <= ST_HOLD;
                  timer       <= '0;
                  done        <= 1'b0;
                  halted      <= 1'b0;
                  cycle_count <= '0;
               end
            end
            default: begin
               state <= ST_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: four instances cover default timing, fast multi-domain, auto-restart, saturation.
module tb_run_controller;

`ifdef RUN_CONTROLLER_HALT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   localparam logic [1:0] ST_HOLD = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Instance A: default hold/stagger, 2 domains, 20-cycle budget
   logic        a_rst, a_halt, a_restart;
   logic [1:0]  a_dom;
   logic        a_run, a_done, a_hlt;
   logic [20:0] a_cnt;
   logic [1:0]  a_st;

   run_controller #(.RUN_CYCLES(20)) u_a (
      .CLOCK_50(clk), .reset(a_rst), .halt_req(a_halt), .restart(a_restart),
      .domain_rst_n(a_dom), .running(a_run), .done(a_done), .halted(a_hlt),
      .cycle_count(a_cnt), .state(a_st)
   );

   // Instance B: 3 domains, 1-cycle hold and stagger, 5-cycle budget
   logic        b_rst, b_halt, b_restart;
   logic [2:0]  b_dom;
   logic        b_run, b_done, b_hlt;
   logic [3:0]  b_cnt;
   logic [1:0]  b_st;

   run_controller #(.NUM_DOMAINS(3), .HOLD_CYCLES(1), .STAGGER_CYCLES(1),
                    .RUN_CYCLES(5), .CNT_W(4)) u_b (
      .CLOCK_50(clk), .reset(b_rst), .halt_req(b_halt), .restart(b_restart),
      .domain_rst_n(b_dom), .running(b_run), .done(b_done), .halted(b_hlt),
      .cycle_count(b_cnt), .state(b_st)
   );

   // Instance C: auto-restart, 1 domain
   logic        c_rst, c_halt, c_restart;
   logic [0:0]  c_dom;
   logic        c_run, c_done, c_hlt;
   logic [3:0]  c_cnt;
   logic [1:0]  c_st;

   run_controller #(.NUM_DOMAINS(1), .HOLD_CYCLES(2), .RUN_CYCLES(3),
                    .CNT_W(4), .AUTO_RESTART(1)) u_c (
      .CLOCK_50(clk), .reset(c_rst), .halt_req(c_halt), .restart(c_restart),
      .domain_rst_n(c_dom), .running(c_run), .done(c_done), .halted(c_hlt),
      .cycle_count(c_cnt), .state(c_st)
   );

   // Instance D: unbounded run, 4-bit counter
   logic        d_rst, d_halt, d_restart;
   logic [0:0]  d_dom;
   logic        d_run, d_done, d_hlt;
   logic [3:0]  d_cnt;
   logic [1:0]  d_st;

   run_controller #(.NUM_DOMAINS(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1),
                    .RUN_CYCLES(0), .CNT_W(4)) u_d (
      .CLOCK_50(clk), .reset(d_rst), .halt_req(d_halt), .restart(d_restart),
      .domain_rst_n(d_dom), .running(d_run), .done(d_done), .halted(d_hlt),
      .cycle_count(d_cnt), .state(d_st)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0; d_rst = 1'b0;
      a_halt = 1'b0; b_halt = 1'b0; c_halt = 1'b0; d_halt = 1'b0;
      a_restart = 1'b0; b_restart = 1'b0; c_restart = 1'b0; d_restart = 1'b0;
      repeat (5) tick();
      vec_cnt++;
      if ({a_dom, a_run, a_done, a_hlt, a_cnt, a_st} !== {2'b00, 3'b000, 21'd0, ST_HOLD}) begin
         err_cnt++;
         $display("FAIL reset_a: got dom=%b run=%b done=%b halted=%b cnt=%0d st=%0d, want all zero",
                  a_dom, a_run, a_done, a_hlt, a_cnt, a_st);
      end
      vec_cnt++;
      if ({b_dom, b_run, b_done, b_hlt, b_cnt} !== {3'b000, 3'b000, 4'd0}) begin
         err_cnt++;
         $display("FAIL reset_b: got dom=%b run=%b done=%b halted=%b cnt=%0d, want all zero",
                  b_dom, b_run, b_done, b_hlt, b_cnt);
      end
   endtask

   task automatic test_release_timing();
      logic [1:0] exp_dom;
      a_rst = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         tick();
         exp_dom = (e >= 14) ? 2'b11 : ((e >= 10) ? 2'b01 : 2'b00);
         vec_cnt++;
         if ({a_dom, a_run} !== {exp_dom, (e >= 14)}) begin
            err_cnt++;
            $display("FAIL release_edge%0d: got dom=%b run=%b, want dom=%b run=%b",
                     e, a_dom, a_run, exp_dom, (e >= 14));
         end
      end
      vec_cnt++;
      if ({a_st, a_cnt} !== {ST_RUN, 21'd0}) begin
         err_cnt++;
         $display("FAIL run_entry: got st=%0d cnt=%0d, want st=2 cnt=0", a_st, a_cnt);
      end
   endtask

   task automatic test_halt();
      for (int i = 1; i <= 6; i++) begin
         tick();
         vec_cnt++;
         if (a_cnt !== 21'(i)) begin
            err_cnt++;
            $display("FAIL run_count%0d: got %0d, want %0d", i, a_cnt, i);
         end
      end
      a_halt = 1'b1;
      tick();
      a_halt = 1'b0;
      vec_cnt++;
      if ({a_cnt, a_done, a_hlt, a_run} !== {21'd7, HALT_EN, HALT_EN, !HALT_EN}) begin
         err_cnt++;
         $display("FAIL halt_edge7: got cnt=%0d done=%b halted=%b run=%b, want cnt=7 done=%b halted=%b run=%b",
                  a_cnt, a_done, a_hlt, a_run, HALT_EN, HALT_EN, !HALT_EN);
      end
      if (!HALT_EN) repeat (13) tick();
      vec_cnt++;
      if ({a_cnt, a_done, a_hlt, a_run, a_dom} !== {(HALT_EN ? 21'd7 : 21'd20), 1'b1, HALT_EN, 1'b0, 2'b00}) begin
         err_cnt++;
         $display("FAIL halt_done: got cnt=%0d done=%b halted=%b run=%b dom=%b, want cnt=%0d done=1 halted=%b run=0 dom=00",
                  a_cnt, a_done, a_hlt, a_run, a_dom, (HALT_EN ? 7 : 20), HALT_EN);
      end
      repeat (3) tick();
      vec_cnt++;
      if ({a_cnt, a_done} !== {(HALT_EN ? 21'd7 : 21'd20), 1'b1}) begin
         err_cnt++;
         $display("FAIL done_hold: got cnt=%0d done=%b, want cnt=%0d done=1", a_cnt, a_done, (HALT_EN ? 7 : 20));
      end
   endtask

   task automatic test_halt_on_expiry();
      a_restart = 1'b1;
      tick();
      a_restart = 1'b0;
      vec_cnt++;
      if ({a_st, a_done, a_hlt, a_cnt} !== {ST_HOLD, 2'b00, 21'd0}) begin
         err_cnt++;
         $display("FAIL restart_a: got st=%0d done=%b halted=%b cnt=%0d, want st=0 done=0 halted=0 cnt=0",
                  a_st, a_done, a_hlt, a_cnt);
      end
      repeat (13) tick();
      vec_cnt++;
      if ({a_dom, a_run} !== 3'b010) begin
         err_cnt++;
         $display("FAIL restart_rel13: got dom=%b run=%b, want dom=01 run=0", a_dom, a_run);
      end
      tick();
      vec_cnt++;
      if ({a_dom, a_run, a_cnt} !== {3'b111, 21'd0}) begin
         err_cnt++;
         $display("FAIL restart_rel14: got dom=%b run=%b cnt=%0d, want dom=11 run=1 cnt=0", a_dom, a_run, a_cnt);
      end
      repeat (19) tick();
      vec_cnt++;
      if ({a_cnt, a_done} !== {21'd19, 1'b0}) begin
         err_cnt++;
         $display("FAIL pre_expiry: got cnt=%0d done=%b, want cnt=19 done=0", a_cnt, a_done);
      end
      a_halt = 1'b1;
      tick();
      a_halt = 1'b0;
      vec_cnt++;
      if ({a_cnt, a_done, a_hlt} !== {21'd20, 1'b1, HALT_EN}) begin
         err_cnt++;
         $display("FAIL halt_expiry: got cnt=%0d done=%b halted=%b, want cnt=20 done=1 halted=%b",
                  a_cnt, a_done, a_hlt, HALT_EN);
      end
   endtask

   task automatic test_async_reset();
      b_rst = 1'b1;
      tick();
      vec_cnt++;
      if (b_dom !== 3'b001) begin
         err_cnt++;
         $display("FAIL pre_async: got dom=%b, want 001", b_dom);
      end
      #2;
      b_rst = 1'b0;
      #1;
      vec_cnt++;
      if ({b_dom, b_run, b_st} !== {3'b000, 1'b0, ST_HOLD}) begin
         err_cnt++;
         $display("FAIL async_reset: got dom=%b run=%b st=%0d, want dom=000 run=0 st=0", b_dom, b_run, b_st);
      end
      tick();
      b_rst = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         tick();
         vec_cnt++;
         if ({b_dom, b_run} !== {3'((1 << e) - 1), (e == 3)}) begin
            err_cnt++;
            $display("FAIL stagger_edge%0d: got dom=%b run=%b, want dom=%b run=%b",
                     e, b_dom, b_run, 3'((1 << e) - 1), (e == 3));
         end
      end
   endtask

   task automatic test_restart();
      tick();
      b_restart = 1'b1;
      tick();
      b_restart = 1'b0;
      vec_cnt++;
      if ({b_run, b_done, b_cnt} !== {2'b10, 4'd2}) begin
         err_cnt++;
         $display("FAIL restart_in_run: got run=%b done=%b cnt=%0d, want run=1 done=0 cnt=2", b_run, b_done, b_cnt);
      end
      repeat (3) tick();
      vec_cnt++;
      if ({b_done, b_run, b_hlt, b_cnt, b_dom} !== {3'b100, 4'd5, 3'b000}) begin
         err_cnt++;
         $display("FAIL budget_b: got done=%b run=%b halted=%b cnt=%0d dom=%b, want done=1 run=0 halted=0 cnt=5 dom=000",
                  b_done, b_run, b_hlt, b_cnt, b_dom);
      end
      tick();
      b_restart = 1'b1;
      tick();
      b_restart = 1'b0;
      vec_cnt++;
      if ({b_done, b_cnt, b_st} !== {1'b0, 4'd0, ST_HOLD}) begin
         err_cnt++;
         $display("FAIL restart_b: got done=%b cnt=%0d st=%0d, want done=0 cnt=0 st=0", b_done, b_cnt, b_st);
      end
      for (int e = 1; e <= 3; e++) begin
         tick();
         vec_cnt++;
         if ({b_dom, b_run} !== {3'((1 << e) - 1), (e == 3)}) begin
            err_cnt++;
            $display("FAIL repeat_edge%0d: got dom=%b run=%b, want dom=%b run=%b",
                     e, b_dom, b_run, 3'((1 << e) - 1), (e == 3));
         end
      end
      repeat (4) tick();
      vec_cnt++;
      if ({b_done, b_cnt} !== {1'b0, 4'd4}) begin
         err_cnt++;
         $display("FAIL repeat_run4: got done=%b cnt=%0d, want done=0 cnt=4", b_done, b_cnt);
      end
      tick();
      vec_cnt++;
      if ({b_done, b_cnt} !== {1'b1, 4'd5}) begin
         err_cnt++;
         $display("FAIL repeat_done: got done=%b cnt=%0d, want done=1 cnt=5", b_done, b_cnt);
      end
   endtask

   task automatic test_auto_restart();
      int  p;
      logic exp_run, exp_done;
      logic [3:0] exp_cnt;
      c_rst = 1'b1;
      for (int e = 1; e <= 14; e++) begin
         tick();
         p        = (e >= 2) ? ((e - 2) % 6) : 5;
         exp_run  = (p < 3);
         exp_done = (p == 3);
         exp_cnt  = (p <= 3) ? 4'(p) : 4'd0;
         vec_cnt++;
         if ({c_dom, c_run, c_done, c_cnt} !== {exp_run, exp_run, exp_done, exp_cnt}) begin
            err_cnt++;
            $display("FAIL auto_edge%0d: got dom=%b run=%b done=%b cnt=%0d, want dom=%b run=%b done=%b cnt=%0d",
                     e, c_dom, c_run, c_done, c_cnt, exp_run, exp_run, exp_done, exp_cnt);
         end
      end
   endtask

   task automatic test_saturation();
      d_rst = 1'b1;
      tick();
      for (int i = 1; i <= 20; i++) begin
         tick();
         vec_cnt++;
         if ({d_cnt, d_run, d_done} !== {((i < 15) ? 4'(i) : 4'd15), 2'b10}) begin
            err_cnt++;
            $display("FAIL sat_edge%0d: got cnt=%0d run=%b done=%b, want cnt=%0d run=1 done=0",
                     i, d_cnt, d_run, d_done, ((i < 15) ? i : 15));
         end
      end
      d_halt = 1'b1;
      tick();
      d_halt = 1'b0;
      vec_cnt++;
      if ({d_cnt, d_done, d_hlt, d_run} !== {4'd15, HALT_EN, HALT_EN, !HALT_EN}) begin
         err_cnt++;
         $display("FAIL sat_halt: got cnt=%0d done=%b halted=%b run=%b, want cnt=15 done=%b halted=%b run=%b",
                  d_cnt, d_done, d_hlt, d_run, HALT_EN, HALT_EN, !HALT_EN);
      end
   endtask

   initial begin
      test_reset();
      test_release_timing();
      test_halt();
      test_halt_on_expiry();
      test_async_reset();
      test_restart();
      test_auto_restart();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
